iq_sched: RTL and testbench
===========================

IQ_SCHED -- requirements
Module: iq_sched

Interface
REQ-001 Parameter DEPTH, default 8, number of iq_entry instances managed (power of two, 2..16).
REQ-002 Parameter IDX_W, default $clog2(DEPTH), entry index width.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  pipeline flush; kills the cycle's enqueue and issue.
REQ-006 enq_valid  in  1  dispatch offers one instruction.
REQ-007 enq_ready  out  1  a free entry exists and flush=0.
REQ-008 enq_prs1 / enq_prs2  in  `PREG_LENGTH each  source pregs of the offered instruction.
REQ-009 enq_src1_state / enq_src2_state  in  1 each  busy bits from busy table (1=not ready).
REQ-010 enq_src1_state_fwd / enq_src2_state_fwd  out  1 each  busy bits after same-cycle wakeup bypass, routed to entries.
REQ-011 entry_enq  out  DEPTH  one-hot per-entry enq_valid.
REQ-012 entry_valid  in  DEPTH  per-entry valid.
REQ-013 entry_ready  in  DEPTH  per-entry ready_to_go.
REQ-014 entry_prs1 / entry_prs2  in  DEPTH*`PREG_LENGTH each  flattened per-entry source pregs.
REQ-015 wb_valid  in  1  writeback broadcast valid.
REQ-016 wb_prd  in  `PREG_LENGTH  writeback destination preg.
REQ-017 entry_wakeup_src1 / entry_wakeup_src2  out  DEPTH each  per-entry wakeup strobes.
REQ-018 entry_issuing  out  DEPTH  one-hot per-entry issuing strobe.
REQ-019 issue_valid  out  1  an entry is selected for issue.
REQ-020 issue_idx  out  IDX_W  selected entry index (payload mux select).
REQ-021 issue_ready  in  1  execution unit accepts this cycle.
REQ-022 iq_count  out  IDX_W+1  registered occupancy.

Function
REQ-023 Allocation: enq_fire = enq_valid & enq_ready; entry_enq = one-hot of lowest-index i with entry_valid[i]=0, zero when enq_fire=0.
REQ-024 enq_ready = (entry_valid != all-ones) & ~flush; an entry issuing this cycle is not reusable until next cycle.
REQ-025 Wakeup: entry_wakeup_srcN[i] = wb_valid & entry_valid[i] & (entry_prsN[i] == wb_prd), combinational.
REQ-026 Bypass: enq_srcN_state_fwd = enq_srcN_state & ~(wb_valid & enq_prsN == wb_prd), covering enqueue priority over wakeup inside the entry.
REQ-027 Age matrix: DEPTH x DEPTH register, age[i][j]=1 means entry i older than entry j; diagonal ignored.
REQ-028 On enq_fire into entry k: age[j][k] <= entry_valid[j] for all j != k; age[k][j] <= 0 for all j; other bits hold.
REQ-029 Select: grant[i] = entry_ready[i] & no j with entry_ready[j] & age[j][i]; exactly one bit set whenever any entry_ready.
REQ-030 issue_valid = |entry_ready & ~flush; issue_idx = encode(grant), 0 when issue_valid=0.
REQ-031 entry_issuing = grant when issue_valid & issue_ready, else 0; issue_valid holds the same grant while issue_ready=0 unless an older entry becomes ready.
REQ-032 Latency: enqueue to earliest issue = 1 cycle (entry registers on enq, ready_to_go next cycle).
REQ-033 iq_count <= iq_count + enq_fire - |entry_issuing each cycle; simultaneous enq and issue leaves count unchanged; never exceeds DEPTH nor wraps below 0.
REQ-034 Flush: entry_enq=0, entry_issuing=0, iq_count <= 0 next cycle; age matrix not required to clear (masked by entry_valid).

Reset
REQ-035 Asynchronous assertion of reset_n=0 clears age matrix and iq_count to 0 immediately, irrespective of clock.
REQ-036 While reset_n=0: enq_ready=0-independent of entry_valid is not required; outputs derive combinationally from entry inputs, which are themselves 0 in reset, so entry_enq, entry_issuing, issue_valid, issue_idx, wakeups read 0.
REQ-037 Reset mid-operation discards all age ordering; first post-reset enqueue sees an empty queue.

Structure
REQ-038 `PREG_LENGTH/`PREG_RANGE from the shared defines header; no new global constants.
REQ-039 One sub-module iq_age_select (age matrix storage + oldest-ready grant), instantiated once; allocation, wakeup, count in iq_sched.

Verification
REQ-040 Empty queue, enq_valid=1 x3 → entries 0,1,2 allocated in order, iq_count=3 after 3 cycles.
REQ-041 Entries 2,0 enqueued in that order (0 freed earlier), both ready → issue_idx=2 first, then 0.
REQ-042 Enq prs1=5, state=1, wb_valid=1 wb_prd=5 same cycle → enq_src1_state_fwd=0, entry issues next cycle.
REQ-043 All DEPTH valid → enq_ready=0; same cycle issue_ready=1 → enq_ready still 0, becomes 1 next cycle; iq_count DEPTH→DEPTH-1.
REQ-044 issue_ready=0 for 3 cycles with entry 1 ready → issue_valid=1, issue_idx=1 steady, entry_issuing=0; issue_ready=1 → entry_issuing=8'b0000_0010 one cycle.
REQ-045 flush=1 with enq_valid and ready entries → entry_enq=0, entry_issuing=0, iq_count=0 next cycle; reset_n pulse mid-stream → iq_count=0 asynchronously.

Source files
------------

// File: rtl/iq_sched_pkg.sv
// Shared types and helpers for the issue-queue scheduler.
// Latency: none (package only).
// Backpressure: n/a.
//
// PREG_LENGTH / PREG_RANGE normally come from the core-wide defines header.
// These guarded fallbacks let the block build on its own. They never override
// an existing definition.
`ifndef PREG_LENGTH
`define PREG_LENGTH 6
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif

package iq_sched_pkg;

    // Widest queue the helpers below cover. DEPTH is limited to 2..16.
    localparam int IQ_MAX_DEPTH = 16;
    localparam int IQ_MAX_IDX_W = $clog2(IQ_MAX_DEPTH);

    typedef logic [IQ_MAX_DEPTH-1:0] iq_vec_t;

    // Keeps only the lowest set bit of v.
    function automatic iq_vec_t lowest_set(input iq_vec_t v);
        return v & (~v + iq_vec_t'(1));
    endfunction

    // Converts a one-hot vector to its index. All-zero input gives index 0.
    function automatic logic [IQ_MAX_IDX_W-1:0] onehot_to_idx(input iq_vec_t v);
        logic [IQ_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < IQ_MAX_DEPTH; i++) begin
            if (v[i]) idx = idx | IQ_MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/iq_age_select.sv
// Age matrix plus oldest-ready select for the issue queue.
// Latency: the grant is combinational from entry_ready. Age updates are visible the cycle after alloc.
// Backpressure: none. The parent decides whether the grant is consumed.
//
// Ports: clock, reset_n (async active-low); alloc = one-hot entry being
// written this cycle; entry_valid / entry_ready = per-entry status;
// grant = one-hot oldest ready entry.
module iq_age_select
    import iq_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] entry_valid,
    input  logic [DEPTH-1:0] entry_ready,
    output logic [DEPTH-1:0] grant
);

    // age[i][j] = 1 means entry i is older than entry j.
    logic [DEPTH-1:0][DEPTH-1:0] age;
    logic [DEPTH-1:0]            blocked;

    // The new entry becomes younger than every entry that is currently valid.
    // Its own row is cleared, so it is older than nothing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            age <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (alloc[k]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j != k) age[j][k] <= entry_valid[j];
                        age[k][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // An entry is blocked when some other ready entry is older than it.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && entry_ready[j] && age[j][i]) blocked[i] = 1'b1;
            end
        end
    end

    assign grant = entry_ready & ~blocked;

endmodule

// File: rtl/iq_sched.sv
// Issue-queue scheduler: entry allocation, wakeup broadcast, oldest-first issue select and occupancy count.
// Latency: an entry enqueued in cycle N can issue in cycle N+1. Wakeup and select are combinational.
// Backpressure: enq_ready drops when the queue is full or flushing. issue_ready=0 holds the current grant.
//
// Ports: clock/reset_n; flush; enqueue handshake (enq_valid/enq_ready,
// enq_prs*, enq_src*_state, bypassed enq_src*_state_fwd); per-entry strobes
// (entry_enq, entry_wakeup_src*, entry_issuing) and status (entry_valid,
// entry_ready, entry_prs*); writeback (wb_valid, wb_prd); issue handshake
// (issue_valid/issue_ready, issue_idx); iq_count occupancy.
module iq_sched
    import iq_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [`PREG_LENGTH-1:0]       enq_prs1,
    input  logic [`PREG_LENGTH-1:0]       enq_prs2,
    input  logic                          enq_src1_state,
    input  logic                          enq_src2_state,
    output logic                          enq_src1_state_fwd,
    output logic                          enq_src2_state_fwd,
    output logic [DEPTH-1:0]              entry_enq,
    input  logic [DEPTH-1:0]              entry_valid,
    input  logic [DEPTH-1:0]              entry_ready,
    input  logic [DEPTH*`PREG_LENGTH-1:0] entry_prs1,
    input  logic [DEPTH*`PREG_LENGTH-1:0] entry_prs2,
    input  logic                          wb_valid,
    input  logic [`PREG_LENGTH-1:0]       wb_prd,
    output logic [DEPTH-1:0]              entry_wakeup_src1,
    output logic [DEPTH-1:0]              entry_wakeup_src2,
    output logic [DEPTH-1:0]              entry_issuing,
    output logic                          issue_valid,
    output logic [IDX_W-1:0]              issue_idx,
    input  logic                          issue_ready,
    output logic [IDX_W:0]                iq_count
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             enq_fire;
    logic             issue_fire;
    logic [DEPTH-1:0] free_slots;
    logic [DEPTH-1:0] grant;
    logic [CNT_W-1:0] count_nxt;

    // Allocation. An entry that is issuing this cycle still reads as valid,
    // so it cannot be reused until the next cycle.
    assign enq_ready  = (entry_valid != {DEPTH{1'b1}}) & ~flush;
    assign enq_fire   = enq_valid & enq_ready;
    assign free_slots = ~entry_valid;
    assign entry_enq  = enq_fire ? DEPTH'(lowest_set(iq_vec_t'(free_slots))) : '0;

    // Same-cycle writeback bypass. The entry gives enqueue priority over
    // wakeup, so the busy bits it captures must already include this broadcast.
    assign enq_src1_state_fwd = enq_src1_state & ~(wb_valid & (enq_prs1 == wb_prd));
    assign enq_src2_state_fwd = enq_src2_state & ~(wb_valid & (enq_prs2 == wb_prd));

    always_comb begin
        entry_wakeup_src1 = '0;
        entry_wakeup_src2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_wakeup_src1[i] = wb_valid & entry_valid[i] &
                (entry_prs1[i*`PREG_LENGTH +: `PREG_LENGTH] == wb_prd);
            entry_wakeup_src2[i] = wb_valid & entry_valid[i] &
                (entry_prs2[i*`PREG_LENGTH +: `PREG_LENGTH] == wb_prd);
        end
    end

    iq_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc       (entry_enq),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .grant       (grant)
    );

    // Issue select.
    assign issue_valid   = (|entry_ready) & ~flush;
    assign issue_fire    = issue_valid & issue_ready;
    assign issue_idx     = issue_valid ? IDX_W'(onehot_to_idx(iq_vec_t'(grant))) : '0;
    assign entry_issuing = issue_fire ? grant : '0;

    // Occupancy. Enqueue and issue in the same cycle cancel out.
    always_comb begin
        count_nxt = iq_count;
        if (flush) begin
            count_nxt = '0;
        end else if (enq_fire && !issue_fire) begin
            count_nxt = iq_count + CNT_ONE;
        end else if (!enq_fire && issue_fire) begin
            count_nxt = iq_count - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iq_count <= '0;
        end else begin
            iq_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_iq_sched.sv
`ifndef PREG_LENGTH
`define PREG_LENGTH 6
`endif

module tb_iq_sched;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int PL    = `PREG_LENGTH;

    logic                  clock;
    logic                  reset_n;
    logic                  flush;
    logic                  enq_valid;
    logic                  enq_ready;
    logic [PL-1:0]         enq_prs1;
    logic [PL-1:0]         enq_prs2;
    logic                  enq_src1_state;
    logic                  enq_src2_state;
    logic                  enq_src1_state_fwd;
    logic                  enq_src2_state_fwd;
    logic [DEPTH-1:0]      entry_enq;
    logic [DEPTH-1:0]      entry_valid;
    logic [DEPTH-1:0]      entry_ready;
    logic [DEPTH*PL-1:0]   entry_prs1;
    logic [DEPTH*PL-1:0]   entry_prs2;
    logic                  wb_valid;
    logic [PL-1:0]         wb_prd;
    logic [DEPTH-1:0]      entry_wakeup_src1;
    logic [DEPTH-1:0]      entry_wakeup_src2;
    logic [DEPTH-1:0]      entry_issuing;
    logic                  issue_valid;
    logic [IDX_W-1:0]      issue_idx;
    logic                  issue_ready;
    logic [IDX_W:0]        iq_count;

    int n_tests = 0;
    int n_fail  = 0;

    iq_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .flush              (flush),
        .enq_valid          (enq_valid),
        .enq_ready          (enq_ready),
        .enq_prs1           (enq_prs1),
        .enq_prs2           (enq_prs2),
        .enq_src1_state     (enq_src1_state),
        .enq_src2_state     (enq_src2_state),
        .enq_src1_state_fwd (enq_src1_state_fwd),
        .enq_src2_state_fwd (enq_src2_state_fwd),
        .entry_enq          (entry_enq),
        .entry_valid        (entry_valid),
        .entry_ready        (entry_ready),
        .entry_prs1         (entry_prs1),
        .entry_prs2         (entry_prs2),
        .wb_valid           (wb_valid),
        .wb_prd             (wb_prd),
        .entry_wakeup_src1  (entry_wakeup_src1),
        .entry_wakeup_src2  (entry_wakeup_src2),
        .entry_issuing      (entry_issuing),
        .issue_valid        (issue_valid),
        .issue_idx          (issue_idx),
        .issue_ready        (issue_ready),
        .iq_count           (iq_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural stand-in for the iq_entry array the scheduler drives.
    logic [DEPTH-1:0] ev, eb1, eb2;
    logic [PL-1:0]    ep1 [DEPTH];
    logic [PL-1:0]    ep2 [DEPTH];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ev  <= '0;
            eb1 <= '0;
            eb2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ep1[i] <= '0;
                ep2[i] <= '0;
            end
        end else if (flush) begin
            ev <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_enq[i]) begin
                    ev[i]  <= 1'b1;
                    ep1[i] <= enq_prs1;
                    ep2[i] <= enq_prs2;
                    eb1[i] <= enq_src1_state_fwd;
                    eb2[i] <= enq_src2_state_fwd;
                end else begin
                    if (entry_issuing[i])     ev[i]  <= 1'b0;
                    if (entry_wakeup_src1[i]) eb1[i] <= 1'b0;
                    if (entry_wakeup_src2[i]) eb2[i] <= 1'b0;
                end
            end
        end
    end

    assign entry_valid = ev;
    assign entry_ready = ev & ~eb1 & ~eb2;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_prs1[i*PL +: PL] = ep1[i];
            entry_prs2[i*PL +: PL] = ep2[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        flush          = 1'b0;
        enq_valid      = 1'b0;
        enq_prs1       = '0;
        enq_prs2       = '0;
        enq_src1_state = 1'b0;
        enq_src2_state = 1'b0;
        wb_valid       = 1'b0;
        wb_prd         = '0;
        issue_ready    = 1'b0;
        #3;
        chk("rst_count",       32'(iq_count),    32'd0);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_entry_enq",   32'(entry_enq),   32'h00);
        @(negedge clock);
        reset_n = 1'b1;

        // Three enqueues into an empty queue land in entries 0, 1, 2.
        tick();
        enq_valid = 1'b1; enq_prs1 = 6'd10; enq_prs2 = 6'd0;
        enq_src1_state = 1'b1; enq_src2_state = 1'b0;
        #1;
        chk("alloc0_ready", 32'(enq_ready), 32'd1);
        chk("alloc0",       32'(entry_enq), 32'h01);
        tick(); enq_prs1 = 6'd11; #1;
        chk("alloc1",       32'(entry_enq), 32'h02);
        tick(); enq_prs1 = 6'd12; #1;
        chk("alloc2",       32'(entry_enq), 32'h04);
        tick(); enq_valid = 1'b0; #1;
        chk("count3",       32'(iq_count),  32'd3);

        // Wake entry 1 only, then stall the issue for 3 cycles.
        wb_valid = 1'b1; wb_prd = 6'd11; #1;
        chk("wake1_src1", 32'(entry_wakeup_src1), 32'h02);
        chk("wake1_src2", 32'(entry_wakeup_src2), 32'h00);
        tick(); wb_valid = 1'b0; #1;
        for (int c = 0; c < 3; c++) begin
            chk("hold_valid",   32'(issue_valid),   32'd1);
            chk("hold_idx",     32'(issue_idx),     32'd1);
            chk("hold_issuing", 32'(entry_issuing), 32'h00);
            tick();
        end
        issue_ready = 1'b1; #1;
        chk("issue1_strobe", 32'(entry_issuing), 32'h02);
        tick(); issue_ready = 1'b0; #1;
        chk("count_after_issue1", 32'(iq_count),    32'd2);
        chk("idle_after_issue1",  32'(issue_valid), 32'd0);

        // Free entry 0, then reuse it. Entry 2 is now older than the new entry 0.
        wb_valid = 1'b1; wb_prd = 6'd10; #1;
        chk("wake0_src1", 32'(entry_wakeup_src1), 32'h01);
        tick(); wb_valid = 1'b0; issue_ready = 1'b1; #1;
        chk("issue0_idx",     32'(issue_idx),     32'd0);
        chk("issue0_issuing", 32'(entry_issuing), 32'h01);
        tick(); issue_ready = 1'b0;
        enq_valid = 1'b1; enq_prs1 = 6'd20; enq_src1_state = 1'b0; enq_src2_state = 1'b0;
        #1;
        chk("realloc0",  32'(entry_enq), 32'h01);
        chk("count1",    32'(iq_count),  32'd1);
        tick(); enq_valid = 1'b0; #1;
        chk("lat1_valid", 32'(issue_valid), 32'd1);
        chk("lat1_idx",   32'(issue_idx),   32'd0);
        chk("count2",     32'(iq_count),    32'd2);
        wb_valid = 1'b1; wb_prd = 6'd12; #1;
        chk("wake2_src1", 32'(entry_wakeup_src1), 32'h04);
        tick(); wb_valid = 1'b0; #1;
        chk("age_first_idx", 32'(issue_idx), 32'd2);
        issue_ready = 1'b1; #1;
        chk("age_first_issuing", 32'(entry_issuing), 32'h04);
        tick(); #1;
        chk("age_second_idx",     32'(issue_idx),     32'd0);
        chk("age_second_issuing", 32'(entry_issuing), 32'h01);
        chk("count_mid",          32'(iq_count),      32'd1);
        tick(); issue_ready = 1'b0; #1;
        chk("count_empty", 32'(iq_count),    32'd0);
        chk("empty_idle",  32'(issue_valid), 32'd0);

        // Same-cycle wakeup bypass on enqueue.
        wb_valid = 1'b1; wb_prd = 6'd5;
        enq_valid = 1'b1; enq_prs1 = 6'd5; enq_src1_state = 1'b1;
        enq_prs2 = 6'd7; enq_src2_state = 1'b1;
        #1;
        chk("fwd1_bypassed", 32'(enq_src1_state_fwd), 32'd0);
        chk("fwd2_kept",     32'(enq_src2_state_fwd), 32'd1);
        enq_src2_state = 1'b0; #1;
        chk("bypass_alloc",  32'(entry_enq), 32'h01);
        tick(); enq_valid = 1'b0; wb_valid = 1'b0; #1;
        chk("bypass_issue_valid", 32'(issue_valid), 32'd1);
        chk("bypass_issue_idx",   32'(issue_idx),   32'd0);
        issue_ready = 1'b1;
        tick(); issue_ready = 1'b0; #1;
        chk("bypass_count", 32'(iq_count), 32'd0);

        // Fill the queue completely. An issue does not free a slot in the same cycle.
        enq_valid = 1'b1; enq_prs1 = 6'd30; enq_src1_state = 1'b1;
        enq_prs2 = 6'd0; enq_src2_state = 1'b0;
        repeat (DEPTH) tick();
        #1;
        chk("full_count", 32'(iq_count),  32'd8);
        chk("full_ready", 32'(enq_ready), 32'd0);
        chk("full_enq",   32'(entry_enq), 32'h00);
        wb_valid = 1'b1; wb_prd = 6'd30;
        tick(); wb_valid = 1'b0; issue_ready = 1'b1; #1;
        chk("full_issue_ready_same", 32'(enq_ready),     32'd0);
        chk("full_issue_idx",        32'(issue_idx),     32'd0);
        chk("full_issuing",          32'(entry_issuing), 32'h01);
        tick(); issue_ready = 1'b0; #1;
        chk("full_count7",  32'(iq_count),  32'd7);
        chk("full_ready_n", 32'(enq_ready), 32'd1);
        chk("full_refill",  32'(entry_enq), 32'h01);
        tick(); #1;
        chk("refull_count", 32'(iq_count),  32'd8);
        chk("refull_oldest", 32'(issue_idx), 32'd1);

        // Flush kills enqueue and issue, then clears the count.
        flush = 1'b1; issue_ready = 1'b1; #1;
        chk("flush_enq",     32'(entry_enq),     32'h00);
        chk("flush_issuing", 32'(entry_issuing), 32'h00);
        chk("flush_ivalid",  32'(issue_valid),   32'd0);
        chk("flush_ready",   32'(enq_ready),     32'd0);
        tick(); issue_ready = 1'b0; #1;
        chk("flush_count",     32'(iq_count),  32'd0);
        chk("flush_empty_enq", 32'(entry_enq), 32'h00);
        tick(); flush = 1'b0; #1;
        chk("post_flush_alloc", 32'(entry_enq), 32'h01);
        tick(); tick(); enq_valid = 1'b0; #1;
        chk("pre_reset_count", 32'(iq_count), 32'd2);

        // Reset asserted mid-cycle clears the count without waiting for a clock edge.
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_count",  32'(iq_count),    32'd0);
        chk("async_reset_ivalid", 32'(issue_valid), 32'd0);
        #2 reset_n = 1'b1;
        tick(); enq_valid = 1'b1; #1;
        chk("post_reset_alloc", 32'(entry_enq), 32'h01);
        tick(); enq_valid = 1'b0; #1;
        chk("post_reset_count", 32'(iq_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
